// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified fetch/data memory arbiter: FSM states,
// requester IDs and the word/byte geometry of the shared memory.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  // Replace byte lane 'lane' of a little-endian word.
  function automatic logic [31:0] put_byte(input logic [31:0]      word,
                                           input logic [CNT_W-1:0] lane,
                                           input logic [7:0]       b);
    logic [31:0] r;
    r = word;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0]      word,
                                          input logic [CNT_W-1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_arb2_rr.sv
// Two-requester arbiter: round-robin when FAIR != 0, otherwise the data
// port always wins. Remembers the last grant taken while the FSM is idle.
module arb2_rr
  import unified_mem_arbiter_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  req_f,
  input  logic  req_d,
  input  logic  take,
  output logic  gnt_vld,
  output port_e gnt
);

  port_e last_q, last_d;

  always_comb begin
    gnt_vld = req_f | req_d;
    gnt     = PORT_FETCH;
    if (req_f && req_d) begin
      if (FAIR != 0) begin
        gnt = (last_q == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
      end else begin
        gnt = PORT_DATA;
      end
    end else if (req_d) begin
      gnt = PORT_DATA;
    end
  end

  always_comb begin
    last_d = last_q;
    if (take && gnt_vld) begin
      last_d = gnt;
    end
  end

  // Resetting to fetch makes the data port win the first contended grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= PORT_FETCH;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one byte-wide asynchronous-read memory between a fetch read port
// and a data read/write port, moving one 32-bit word as four byte beats.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int FAIR   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [31:0]       f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES_PER_WORD - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(BYTES_PER_WORD - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  port_e             gnt_q, gnt_d;
  logic [31:0]       f_rdata_q, f_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              gnt_vld;
  port_e             gnt;
  logic              in_xfer;

  arb2_rr #(
    .FAIR(FAIR)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_f  (f_req),
    .req_d  (d_req),
    .take   (state_q == ST_IDLE),
    .gnt_vld(gnt_vld),
    .gnt    (gnt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          gnt_d   = gnt;
          cnt_d   = '0;
          state_d = ST_XFER;
          if (gnt == PORT_DATA) begin
            addr_d  = d_addr & ALIGN_MASK;
            we_d    = d_we;
            be_d    = d_be;
            wdata_d = d_wdata;
          end else begin
            // Fetch is read-only: clear the write qualifiers outright.
            addr_d  = f_addr & ALIGN_MASK;
            we_d    = 1'b0;
            be_d    = '0;
            wdata_d = '0;
          end
        end
      end
      ST_XFER: begin
        if (!we_q) begin
          if (gnt_q == PORT_DATA) begin
            d_rdata_d = put_byte(d_rdata_q, cnt_q, mem_rdata);
          end else begin
            f_rdata_d = put_byte(f_rdata_q, cnt_q, mem_rdata);
          end
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      gnt_q     <= PORT_FETCH;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Latched request fields are only observed in XFER, so they need no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    we_q    <= we_d;
    be_q    <= be_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    in_xfer   = (state_q == ST_XFER);
    mem_addr  = in_xfer ? (addr_q + ADDR_W'(cnt_q)) : '0;
    mem_wdata = in_xfer ? get_byte(wdata_q, cnt_q) : '0;
    mem_we    = in_xfer & we_q & be_q[cnt_q];
    f_ack     = (state_q == ST_DONE) && (gnt_q == PORT_FETCH);
    d_ack     = (state_q == ST_DONE) && (gnt_q == PORT_DATA);
    busy      = (state_q != ST_IDLE);
    f_rdata   = f_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: vector table of single transfers
// plus hand-written arbitration, abandoned-request and reset-abort sequences.
module tb_unified_mem_arbiter;

  localparam int AW = 8;

  logic          clk;
  logic          rst;
  logic          f_req, d_req, d_we;
  logic [AW-1:0] f_addr, d_addr;
  logic [3:0]    d_be;
  logic [31:0]   d_wdata;
  logic          f_ack, d_ack, mem_we, busy;
  logic [31:0]   f_rdata, d_rdata;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  logic          fx_f_ack, fx_d_ack, fx_mem_we, fx_busy;
  logic [31:0]   fx_f_rdata, fx_d_rdata;
  logic [AW-1:0] fx_mem_addr;
  logic [7:0]    fx_mem_wdata;

  logic [7:0] mem [0:255] = '{0: 8'h00, 1: 8'h00, 2: 8'h03, 3: 8'h8C,
                              16: 8'h11, 17: 8'h22, 18: 8'h33, 19: 8'h44,
                              default: 8'h00};
  int nwr = 0;
  int total = 0;
  int bad = 0;

  unified_mem_arbiter #(.ADDR_W(AW), .FAIR(1)) u_dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  unified_mem_arbiter #(.ADDR_W(AW), .FAIR(0)) u_fix (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(fx_f_ack), .f_rdata(fx_f_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(fx_d_ack), .d_rdata(fx_d_rdata),
    .mem_addr(fx_mem_addr), .mem_wdata(fx_mem_wdata), .mem_we(fx_mem_we),
    .mem_rdata(8'h5A), .busy(fx_busy)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      nwr <= nwr + 1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic        we;
    logic [3:0]  be;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [31:0] exp_word;
    int          exp_nwr;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    logic [7:0] b;
    b = a & 8'hFC;
    return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    n;
    int    w0;
    logic  seen;
    string tag;
    tag = $sformatf("vec%0d", idx);
    w0  = nwr;
    @(negedge clk);
    if (v.port) begin
      d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      f_req = 1'b1; f_addr = v.addr;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 12) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
      if (v.port ? d_ack : f_ack) seen = 1'b1;
    end
    f_req = 1'b0;
    d_req = 1'b0;
    check({tag, "_latency"}, seen ? 32'(n) : 32'd99, 32'd5);
    @(negedge clk);
    check({tag, "_ack_one_cycle"}, 32'(v.port ? d_ack : f_ack), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_rdata"}, v.port ? d_rdata : f_rdata, v.exp_rd);
    check({tag, "_memword"}, mem_word(v.addr), v.exp_word);
    check({tag, "_nwrites"}, 32'(nwr - w0), 32'(v.exp_nwr));
  endtask

  initial begin
    logic [3:0] dseq, fseq;
    int dn, fn, extra_d, acks, w0;
    logic got;

    vecs[0] = '{1'b0, 1'b0, 4'h0, 8'h00, 32'h0,        32'h8C030000, 32'h8C030000, 0};
    vecs[1] = '{1'b1, 1'b1, 4'hF, 8'h04, 32'h00000009, 32'h00000000, 32'h00000009, 4};
    vecs[2] = '{1'b1, 1'b1, 4'h5, 8'h0A, 32'hAABBCCDD, 32'h00000000, 32'h00BB00DD, 2};
    vecs[3] = '{1'b1, 1'b0, 4'h0, 8'h13, 32'h0,        32'h44332211, 32'h44332211, 0};
    vecs[4] = '{1'b1, 1'b0, 4'h0, 8'h05, 32'h0,        32'h00000009, 32'h00000009, 0};
    vecs[5] = '{1'b0, 1'b0, 4'hF, 8'h0B, 32'hFFFFFFFF, 32'h00BB00DD, 32'h00BB00DD, 0};

    rst = 1'b0;
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acks", {30'd0, f_ack, d_ack}, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_f_rdata", f_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_fix_idle", {29'd0, fx_busy, fx_mem_we, fx_d_ack}, 32'd0);
    rst = 1'b1;

    // Contention: both requests held from right after reset.
    @(negedge clk);
    f_addr = 8'h00; d_addr = 8'h04; d_we = 1'b0;
    f_req = 1'b1; d_req = 1'b1;
    dseq = '0; fseq = '0; dn = 0; fn = 0;
    for (int c = 0; c < 40 && dn < 4; c++) begin
      @(negedge clk);
      if ((d_ack || f_ack) && dn < 4) begin
        dseq[dn] = d_ack;
        dn++;
      end
      if ((fx_d_ack || fx_f_ack) && fn < 4) begin
        fseq[fn] = fx_d_ack;
        fn++;
      end
    end
    check("rr_count", 32'(dn), 32'd4);
    check("rr_order_DFDF", 32'(dseq), 32'h5);
    check("fixed_count", 32'(fn), 32'd4);
    check("fixed_order_DDDD", 32'(fseq), 32'hF);
    d_req = 1'b0;
    got = 1'b0; extra_d = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (fx_f_ack) got = 1'b1;
      if (fx_d_ack) extra_d++;
    end
    check("fixed_fetch_after_drop", 32'(got), 32'd1);
    check("fixed_no_extra_data", 32'(extra_d), 32'd0);
    f_req = 1'b0;
    do_reset();

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i);
    end

    // Requester withdraws right after being sampled; the transfer completes.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h00;
    @(posedge clk);
    @(negedge clk);
    d_req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (d_ack) got = 1'b1;
    end
    check("drop_ack", 32'(got), 32'd1);
    check("drop_d_rdata", d_rdata, 32'h8C030000);
    check("f_rdata_held", f_rdata, 32'h00BB00DD);
    repeat (2) @(negedge clk);

    // Reset while the third byte of a full write is on the bus.
    w0 = nwr;
    acks = 0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 8'h00; d_wdata = 32'h55667788;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_we_before", 32'(mem_we), 32'd1);
    check("abort_addr_before", 32'(mem_addr), 32'd2);
    rst = 1'b0;
    #1;
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_d_ack", 32'(d_ack), 32'd0);
    d_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (d_ack) acks++;
    end
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (d_ack) acks++;
    end
    check("abort_no_ack", 32'(acks), 32'd0);
    check("abort_nwrites", 32'(nwr - w0), 32'd2);
    check("abort_memword", mem_word(8'h00), 32'h8C037788);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
